// File: rtl/shift_result_buffer.sv
// Result buffer for a 32-bit shifter: tags each issued operation, captures the
// shifter result one cycle later, and presents results in issue order through a
// first-word fall-through queue with a sticky overflow-attempt flag.
module shift_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_ready,
    input  logic [31:0]              Z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_sign,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [31:0]      r_data [DEPTH];
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic             r_zero [DEPTH];
    logic             r_sign [DEPTH];

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_pend_valid;
    logic [TAG_W-1:0] r_pend_tag;
    logic             r_drop_err;

    logic [CW:0]      w_occupancy;
    logic             w_accept;
    logic             w_capture;
    logic             w_pop;

    // Occupancy counts the in-flight result so a slot is reserved at issue time.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_pend_valid};
    assign issue_ready = (w_occupancy < DEPTH_OCC);
    assign w_accept    = issue_valid & issue_ready;
    assign w_capture   = r_pend_valid;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;

    assign out_data = r_data[r_rptr];
    assign out_tag  = r_tag[r_rptr];
    assign out_zero = r_zero[r_rptr];
    assign out_sign = r_sign[r_rptr];
    assign count    = r_count;
    assign drop_err = r_drop_err;

    // Control state: pending slot, pointers, occupancy and sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_tag   <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_tag   <= issue_tag;
            end else if (w_capture) begin
                r_pend_valid <= 1'b0;
            end
            if (issue_valid && !issue_ready) begin
                r_drop_err <= 1'b1;
            end
            if (w_capture) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_capture && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_capture) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Result storage, written with the shifter output one cycle after issue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
                r_zero[i] <= 1'b0;
                r_sign[i] <= 1'b0;
            end
        end else if (w_capture) begin
            r_data[r_wptr] <= Z;
            r_tag[r_wptr]  <= r_pend_tag;
            r_zero[r_wptr] <= (Z == 32'd0);
            r_sign[r_wptr] <= Z[31];
        end
    end

    // A capture into a full buffer would overwrite the head entry.
    a_no_write_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        r_pend_valid |-> (r_count != DEPTH_CNT));

    a_count_in_range: assert property (@(posedge clock) disable iff (!reset_n)
        r_count <= DEPTH_CNT);

endmodule

// File: tb/tb_shift_result_buffer.sv
// Self-checking bench for shift_result_buffer: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_shift_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic             issue_ready;
    logic [31:0]      Z = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_sign;
    logic [2:0]       count;
    logic             drop_err;

    shift_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .Z           (Z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_zero    (out_zero),
        .out_sign    (out_sign),
        .count       (count),
        .drop_err    (drop_err)
    );

    always #5 clock = ~clock;

    // Reference model: an ordered list of stored results plus one in-flight slot.
    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
    } ent_t;
    ent_t             m_q[$];
    logic             m_pend = 1'b0;
    logic [TAG_W-1:0] m_pend_tag = '0;
    logic             m_drop = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_pend = 1'b0;
        m_pend_tag = '0;
        m_drop = 1'b0;
    endfunction

    function automatic void check_model();
        int unsigned occ;
        occ = m_q.size() + (m_pend ? 1 : 0);
        chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_ready", 32'(issue_ready), 32'(occ < DEPTH));
        chk("m_drop", 32'(drop_err), 32'(m_drop));
        if (m_q.size() != 0) begin
            chk("m_data", out_data, m_q[0].d);
            chk("m_tag", 32'(out_tag), 32'(m_q[0].t));
            chk("m_zero", 32'(out_zero), 32'(m_q[0].d == 32'd0));
            chk("m_sign", 32'(out_sign), 32'(m_q[0].d[31]));
        end
    endfunction

    // One clock: drive inputs, advance model on the edge, then present the
    // shifter result for the operation offered this cycle.
    task automatic step(input logic iv, input logic [TAG_W-1:0] tg,
                        input logic [31:0] z, input logic rd);
        logic m_ready, m_accept, m_pop;
        issue_valid = iv;
        issue_tag   = tg;
        out_ready   = rd;
        m_ready  = (m_q.size() + (m_pend ? 1 : 0)) < DEPTH;
        m_accept = iv && m_ready;
        m_pop    = (m_q.size() != 0) && rd;
        @(posedge clock);
        if (m_pop) void'(m_q.pop_front());
        if (m_pend) m_q.push_back('{d: Z, t: m_pend_tag});
        m_pend = m_accept;
        if (m_accept) m_pend_tag = tg;
        if (iv && !m_ready) m_drop = 1'b1;
        #1;
        Z = z;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(issue_ready), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_drop"}, 32'(drop_err), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_tag"}, 32'(out_tag), 32'd0);
        chk({tag, "_zero"}, 32'(out_zero), 32'd0);
        chk({tag, "_sign"}, 32'(out_sign), 32'd0);
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        reset_n     = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst_during");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_reset_outputs("rst_after");
    endtask

    typedef struct {
        logic             iv;
        logic [TAG_W-1:0] tg;
        logic [31:0]      z;
        logic             rd;
        logic             e_valid;
        logic [31:0]      e_data;
        logic [TAG_W-1:0] e_tag;
        logic             e_zero;
        logic             e_sign;
        logic [2:0]       e_count;
        logic             e_ready;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int accepted;
        // Single issue with sign bit, then a zero result and its pop.
        vecs[0] = '{1'b1, 4'd3, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[1] = '{1'b0, 4'd0, 32'h1234_5678, 1'b0, 1'b1, 32'h8000_0000, 4'd3, 1'b0, 1'b1,
                    3'd1, 1'b1};
        vecs[2] = '{1'b1, 4'd5, 32'h0, 1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 4'd5, 1'b1, 1'b0, 3'd1, 1'b1};
        vecs[4] = '{1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].iv, vecs[i].tg, vecs[i].z, vecs[i].rd);
            chk("vec_valid", 32'(out_valid), 32'(vecs[i].e_valid));
            chk("vec_count", 32'(count), 32'(vecs[i].e_count));
            chk("vec_ready", 32'(issue_ready), 32'(vecs[i].e_ready));
            if (vecs[i].e_valid) begin
                chk("vec_data", out_data, vecs[i].e_data);
                chk("vec_tag", 32'(out_tag), 32'(vecs[i].e_tag));
                chk("vec_zero", 32'(out_zero), 32'(vecs[i].e_zero));
                chk("vec_sign", 32'(out_sign), 32'(vecs[i].e_sign));
            end
        end

        // Fill with consumer stalled, attempt an overflow, then drain in order.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            if (!issue_ready) break;
            step(1'b1, 4'(i), $urandom, 1'b0);
            accepted++;
        end
        chk("fill_accepted", 32'(accepted), 32'd4);
        chk("fill_ready_low", 32'(issue_ready), 32'd0);
        step(1'b0, 4'd0, 32'h0, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        step(1'b1, 4'd9, 32'hDEAD_BEEF, 1'b0);
        chk("viol_drop", 32'(drop_err), 32'd1);
        chk("viol_count", 32'(count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", 32'(out_tag), 32'(k));
            step(1'b0, 4'd0, 32'h0, 1'b1);
        end
        step(1'b0, 4'd0, 32'h0, 1'b1);
        chk("drain_empty_valid", 32'(out_valid), 32'd0);
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drop_sticky", 32'(drop_err), 32'd1);

        // Streaming: one result per cycle with steady occupancy.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'(i), $urandom, 1'b1);
            if (i >= 1) begin
                chk("stream_count", 32'(count), 32'd1);
                chk("stream_valid", 32'(out_valid), 32'd1);
            end
            chk("stream_ready", 32'(issue_ready), 32'd1);
            chk("stream_drop", 32'(drop_err), 32'd0);
        end

        // Reset between edges with three stored results and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 8), $urandom | 32'h1, 1'b0);
        chk("midrst_pre_count", 32'(count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(issue_ready), 32'd1);
        model_clear();
        issue_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 32'h0, 1'b1);
            chk("midrst_no_ghost", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with varying consumer back-pressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] z;
            int unsigned rd_pct;
            rd_pct = (i < 200) ? 3 : ((i < 400) ? 8 : 5);
            z = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step(logic'($urandom_range(0, 9) < 7), 4'($urandom), z,
                 logic'($urandom_range(0, 9) < rd_pct));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_result_buffer.md
SHIFT_RESULT_BUFFER -- requirements
Module: shift_result_buffer

Interface
REQ-001 Parameter DEPTH, 4, number of result entries (power of two, 2..16).
REQ-002 Parameter TAG_W, 4, width of the operation tag.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  upstream presents an operation to the 32-bit shifter this cycle; the shifter samples its operands on the same edge.
REQ-006 issue_tag  in  TAG_W  tag of the issued operation.
REQ-007 issue_ready  out  1  buffer can absorb one more result.
REQ-008 Z  in  32  shifter result, valid the cycle after the shifter samples.
REQ-009 out_valid  out  1  head entry available.
REQ-010 out_ready  in  1  consumer accepts the head entry.
REQ-011 out_data  out  32  head result.
REQ-012 out_tag  out  TAG_W  head tag.
REQ-013 out_zero  out  1  head result equals 0.
REQ-014 out_sign  out  1  bit 31 of the head result.
REQ-015 count  out  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-016 drop_err  out  1  sticky protocol-violation flag.

Function
REQ-017 The block SHALL accept an issue on a rising edge when issue_valid=1 and issue_ready=1, setting pend_valid=1 and pend_tag=issue_tag.
REQ-018 On the next rising edge with pend_valid=1, the block SHALL write {Z, pend_tag, Z==0, Z[31]} to the write-pointer entry, advance the write pointer, and clear pend_valid unless a new issue is accepted on that edge.
REQ-019 Back-to-back issues SHALL sustain one result per cycle.
REQ-020 issue_ready SHALL equal (count + pend_valid) < DEPTH and SHALL be a function of registers only, with no combinational path from out_ready or issue_valid.
REQ-021 out_valid SHALL equal (count != 0); out_data, out_tag, out_zero and out_sign SHALL be driven from the read-pointer entry (first-word fall-through).
REQ-022 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1, advancing the read pointer.
REQ-023 Latency SHALL be exactly 2 edges: an issue accepted at edge N gives out_valid=1 after edge N+1 when the buffer was empty.
REQ-024 Simultaneous capture and pop SHALL leave count unchanged; capture only SHALL increment count; pop only SHALL decrement it.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Results SHALL leave in issue order.
REQ-027 Head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 issue_valid=1 while issue_ready=0 SHALL set drop_err=1, SHALL NOT set pend_valid, and SHALL leave count and the pointers unchanged; the shifter result for that operation is discarded.
REQ-029 drop_err SHALL clear only on reset.
REQ-030 The block SHALL never write an entry when count=DEPTH; REQ-020 guarantees this condition and assertions SHALL check it.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately clear count, both pointers, pend_valid and drop_err, independent of clock.
REQ-032 During and after reset, outputs SHALL be out_valid=0, issue_ready=1, and out_data, out_tag, out_zero and out_sign all 0, with storage cleared.
REQ-033 Reset mid-operation SHALL discard all queued and pending results; a pending Z SHALL NOT be captured after release.
REQ-034 The first issue SHALL be acceptable on the first rising edge after reset_n returns to 1.

Verification
REQ-035 Single issue: issue tag=3 at edge N, Z=0x80000000 in the following cycle -> after edge N+1, out_valid=1, out_data=0x80000000, out_tag=3, out_sign=1, out_zero=0, count=1.
REQ-036 Zero flag: issue with Z=0x00000000 -> head shows out_zero=1 and out_sign=0; pop with out_ready=1 -> count=0 and out_valid=0.
REQ-037 Fill: out_ready=0, issue every cycle while issue_ready=1 -> exactly 4 accepted, issue_ready=0 after the 4th issue, count=4, and results come out in tag order 0,1,2,3 once out_ready=1.
REQ-038 Streaming: continuous issue with out_ready=1 -> one result per cycle, count steady at 1, issue_ready held at 1, no drop_err.
REQ-039 Violation: with count=4, pulse issue_valid=1 -> drop_err=1 and stays 1, count stays 4, and no extra entry appears after draining.
REQ-040 Reset mid-op: count=3 and pend_valid=1, then reset_n=0 between edges -> out_valid=0, count=0 and issue_ready=1 immediately; after release, no result appears without a new issue.
